// File: rtl/io_port_responder.sv
// -----------------------------------------------------------------------------
// io_port_responder
//   Bus-side responder for the memory-mapped I/O window. Drives the CPU read
//   data from RAM, the output port (0xFE) or the input port (0xFF). It holds the
//   0xFE output register, which an external consumer drains through a
//   valid/ready handshake. It also holds a one-entry input buffer that an
//   external producer fills. A CPU write to 0xFF acknowledges the buffer and
//   frees it.
//
// Ports
//   clk, rst_n          system clock (rising edge), async active-low reset
//   we_oport0           CPU write strobe for 0xFE (loads output register)
//   we_iport0           CPU write strobe for 0xFF (acknowledges input buffer)
//   sel_ram_io, sel_o_i read-mux selects: 0x=RAM, 10=oport, 11=iport
//   WD, ram_RD          CPU write data, RAM read data
//   RD                  CPU read data (combinational mux)
//   out_data/valid/ready/ovr  output register, handshake, sticky overrun flag
//   in_data/valid/ready/full  producer data, handshake, buffer occupancy
//   rx_cnt, tx_cnt      wrap-around counters of accepted/completed transfers
// -----------------------------------------------------------------------------
module io_port_responder #(
  parameter int             W         = 8,
  parameter int             CNT_W     = 8,
  parameter logic [W-1:0]   OREG_INIT = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_oport0,
  input  logic             we_iport0,
  input  logic             sel_ram_io,
  input  logic             sel_o_i,
  input  logic [W-1:0]     WD,
  input  logic [W-1:0]     ram_RD,
  output logic [W-1:0]     RD,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovr,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             in_full,
  output logic [CNT_W-1:0] rx_cnt,
  output logic [CNT_W-1:0] tx_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [W-1:0]     out_data_r, out_data_s;
  logic             out_valid_r, out_valid_s;
  logic             out_ovr_r, out_ovr_s;
  logic [W-1:0]     ibuf_r, ibuf_s;
  logic             in_full_r, in_full_s;
  logic [CNT_W-1:0] rx_cnt_r, rx_cnt_s;
  logic [CNT_W-1:0] tx_cnt_r, tx_cnt_s;
  logic             out_fire_s;
  logic             in_fire_s;

  // Output-side next state: load, drain, overrun detection, tx counting.
  always_comb begin
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    out_ovr_s   = out_ovr_r;
    tx_cnt_s    = tx_cnt_r;
    out_fire_s  = out_valid_r & out_ready;

    if (out_fire_s) begin
      tx_cnt_s = tx_cnt_r + CNT_ONE;
    end else begin
      tx_cnt_s = tx_cnt_r;
    end

    if (we_oport0) begin
      // A write in the handshake cycle counts as a clean hand-off of the old
      // value. Only a write over an undrained value is an overrun.
      out_data_s  = WD;
      out_valid_s = 1'b1;
      if (out_valid_r & ~out_ready) begin
        out_ovr_s = 1'b1;
      end else begin
        out_ovr_s = out_ovr_r;
      end
    end else if (out_fire_s) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end
  end

  // Input-side next state. Accept and ack cannot coincide because in_ready is
  // low while the buffer is full.
  always_comb begin
    ibuf_s    = ibuf_r;
    in_full_s = in_full_r;
    rx_cnt_s  = rx_cnt_r;
    in_fire_s = in_valid & ~in_full_r;

    if (in_fire_s) begin
      ibuf_s    = in_data;
      in_full_s = 1'b1;
      rx_cnt_s  = rx_cnt_r + CNT_ONE;
    end else if (we_iport0 & in_full_r) begin
      in_full_s = 1'b0;
    end else begin
      in_full_s = in_full_r;
    end
  end

  // State registers. Reset drops any pending transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= OREG_INIT;
      out_valid_r <= 1'b0;
      out_ovr_r   <= 1'b0;
      ibuf_r      <= {W{1'b0}};
      in_full_r   <= 1'b0;
      rx_cnt_r    <= {CNT_W{1'b0}};
      tx_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      out_ovr_r   <= out_ovr_s;
      ibuf_r      <= ibuf_s;
      in_full_r   <= in_full_s;
      rx_cnt_r    <= rx_cnt_s;
      tx_cnt_r    <= tx_cnt_s;
    end
  end

  // Zero-latency CPU read mux. Reading has no side effects.
  always_comb begin
    case ({sel_ram_io, sel_o_i})
      2'b10:   RD = out_data_r;
      2'b11:   RD = ibuf_r;
      default: RD = ram_RD;
    endcase
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_ovr   = out_ovr_r;
  assign in_full   = in_full_r;
  assign in_ready  = ~in_full_r;
  assign rx_cnt    = rx_cnt_r;
  assign tx_cnt    = tx_cnt_r;

endmodule
